// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with a one-slot registered output stage.
// Grant comes from an explicit select (mode=0) or a round-robin search (mode=1).
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic             grant_hit;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             slot_free;
  logic             take;

  // (base + k) mod N for base < N and k < N, without a divider.
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) begin
        grant_hit = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!grant_hit && in_valid[wrap_idx(rr_ptr, k)]) begin
          grant_hit = 1'b1;
          grant_idx = wrap_idx(rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Drain and refill can happen in the same cycle; reset blocks any accept.
  assign slot_free = !out_valid || out_ready;
  assign take      = grant_hit && slot_free && rst_n;

  always_comb begin
    in_ready = '0;
    if (take) in_ready[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant_idx;
      if (mode) rr_ptr <= wrap_idx(grant_idx, 1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
